imem_loader: RTL

Sequential program loader that fills the instruction memory before the CPU runs. It accepts a little-endian byte stream over a valid/ready handshake and packs each group of four bytes into a 32-bit word. It writes those words through the memory's IAddr/IDataIn/RW write port at ascending word addresses, then optionally reads the region back through IDataOut and checks it. While loading it holds the CPU (CpuHold) so the PC does not fetch a half-written program.

---
 rtl/imem_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Program loader: packs a little-endian byte stream into 32-bit words, writes them to
// instruction memory at ascending addresses, optionally reads them back, and holds the CPU.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          MEM_BYTES = 72,
    parameter bit          VERIFY    = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_length,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic [31:0] o_iaddr,
    output logic [31:0] o_idata_in,
    output logic        o_rw,
    input  logic [31:0] i_idata_out,
    output logic        o_busy,
    output logic        o_cpu_hold,
    output logic        o_done,
    output logic        o_error,
    output logic [31:0] o_checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_NEXT,
        S_VRD_ADDR,
        S_VRD_CMP,
        S_DONE
    } state_t;

    localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_word;
    logic [31:0] r_checksum;
    logic [31:0] r_rd_sum;
    logic [7:0]  r_len;
    logic [7:0]  r_word_cnt;
    logic [1:0]  r_byte_idx;
    logic        r_error;

    logic        w_accept;
    logic        w_last_byte;
    logic        w_out_of_range;
    logic [32:0] w_addr_end;
    logic [7:0]  w_cnt_inc;
    logic        w_last_word;
    logic [31:0] w_rd_sum;

    assign w_accept       = (r_state == S_COLLECT) && i_byte_valid;
    assign w_last_byte    = w_accept && (r_byte_idx == 2'd3);
    // 33-bit sum so an address near the top of the 32-bit space cannot wrap past the bound
    assign w_addr_end     = {1'b0, r_addr} + 33'd3;
    assign w_out_of_range = w_addr_end > LAST_BYTE;
    assign w_cnt_inc      = r_word_cnt + 8'd1;
    assign w_last_word    = (w_cnt_inc == r_len);
    assign w_rd_sum       = r_rd_sum ^ i_idata_out;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (i_length == 8'd0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_last_byte) begin
                    w_next = w_out_of_range ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: w_next = S_NEXT;
            S_NEXT: begin
                if (w_last_word) begin
                    w_next = VERIFY ? S_VRD_ADDR : S_DONE;
                end else begin
                    w_next = S_COLLECT;
                end
            end
            S_VRD_ADDR: w_next = S_VRD_CMP;
            S_VRD_CMP:  w_next = w_last_word ? S_DONE : S_VRD_ADDR;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_byte_ready = 1'b0;
        o_rw         = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_COLLECT: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
            end
            S_WRITE: begin
                o_rw   = 1'b1;
                o_busy = 1'b1;
            end
            S_NEXT, S_VRD_ADDR, S_VRD_CMP: o_busy = 1'b1;
            S_DONE:  o_done = 1'b1;
            default: o_busy = 1'b0;
        endcase
    end

    assign o_cpu_hold = o_busy;
    assign o_iaddr    = r_addr;
    assign o_idata_in = r_word;
    assign o_error    = r_error;
    assign o_checksum = r_checksum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr     <= 32'd0;
            r_word     <= 32'd0;
            r_checksum <= 32'd0;
            r_rd_sum   <= 32'd0;
            r_len      <= 8'd0;
            r_word_cnt <= 8'd0;
            r_byte_idx <= 2'd0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_len      <= i_length;
                        r_addr     <= BASE_ADDR;
                        r_byte_idx <= 2'd0;
                        r_word_cnt <= 8'd0;
                        r_checksum <= 32'd0;
                        r_error    <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_word[{r_byte_idx, 3'b000} +: 8] <= i_byte_in;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_last_byte && w_out_of_range) begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_WRITE: r_checksum <= r_checksum ^ r_word;
                S_NEXT: begin
                    // the read-back pass reuses the address and word counters from the base
                    if (w_last_word && VERIFY) begin
                        r_addr     <= BASE_ADDR;
                        r_word_cnt <= 8'd0;
                        r_rd_sum   <= 32'd0;
                    end else begin
                        r_addr     <= r_addr + 32'd4;
                        r_word_cnt <= w_cnt_inc;
                    end
                end
                S_VRD_CMP: begin
                    r_rd_sum   <= w_rd_sum;
                    r_addr     <= r_addr + 32'd4;
                    r_word_cnt <= w_cnt_inc;
                    if (w_last_word) begin
                        r_error <= r_error | (w_rd_sum != r_checksum);
                    end
                end
                default: r_len <= r_len;
            endcase
        end
    end

endmodule
